// File: rtl/vga_framebuf_db.sv
// rtl/vga_framebuf_db.sv - double-buffered multi-channel VGA framebuffer with CPU port, bank clear and frame-synced swap
module vga_framebuf_db #(
  parameter int NUM_CH  = 3,
  parameter int CH_BITS = 4,
  parameter int H_PIX   = 160,
  parameter int V_PIX   = 120
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [31:0]                 i_addr,
  input  logic [31:0]                 i_wdata,
  input  logic                        i_we,
  input  logic                        i_re,
  output logic [31:0]                 o_rdata,
  output logic                        o_rvalid,
  output logic                        o_err,
  input  logic                        i_clr_req,
  input  logic [NUM_CH*CH_BITS-1:0]   i_clr_val,
  output logic                        o_busy,
  input  logic                        i_swap_req,
  input  logic                        i_frame_start,
  output logic                        o_front,
  input  logic                        i_pxl_req,
  input  logic [7:0]                  i_pxlX,
  input  logic [7:0]                  i_pxlY,
  output logic [NUM_CH*CH_BITS-1:0]   o_color,
  output logic                        o_color_valid
);

  localparam int NPIX  = H_PIX * V_PIX;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PIX_W = NUM_CH * CH_BITS;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t               state;
  logic [IDX_W-1:0]     clr_idx;
  logic [PIX_W-1:0]     clr_val_q;
  logic                 pending;

  // Two banks, each a separate word array per colour channel; not reset.
  logic [CH_BITS-1:0]   mem [2][NUM_CH][NPIX];

  logic [7:0]           cpu_x, cpu_y, cpu_ch;
  logic                 cpu_ok;
  logic [IDX_W-1:0]     cpu_idx;
  logic [CH_W-1:0]      cpu_ch_i;
  logic                 back;
  logic                 pxl_ok;
  logic [IDX_W-1:0]     pxl_idx;
  logic [PIX_W-1:0]     pxl_word;
  logic                 unused_bits;

  assign back     = ~o_front;
  assign cpu_x    = i_addr[7:0];
  assign cpu_y    = i_addr[15:8];
  assign cpu_ch   = i_addr[23:16];
  assign cpu_ch_i = CH_W'(cpu_ch);
  assign cpu_idx  = IDX_W'(cpu_y) * IDX_W'(H_PIX) + IDX_W'(cpu_x);
  // Any access during a clear is rejected so the clear owns the back bank.
  assign cpu_ok   = (int'(cpu_x) < H_PIX) && (int'(cpu_y) < V_PIX) &&
                    (int'(cpu_ch) < NUM_CH) && !o_busy;
  assign pxl_ok   = (int'(i_pxlX) < H_PIX) && (int'(i_pxlY) < V_PIX);
  assign pxl_idx  = IDX_W'(i_pxlY) * IDX_W'(H_PIX) + IDX_W'(i_pxlX);
  assign unused_bits = ^{i_addr[31:24], i_wdata[31:CH_BITS]};

  // Gather all channels of the addressed front-bank pixel.
  always_comb begin
    pxl_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pxl_word[c*CH_BITS +: CH_BITS] = mem[o_front][c][pxl_idx];
    end
  end

  // Back-bank writes: clear sweep has priority, CPU writes only when valid.
  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[back][c][clr_idx] <= clr_val_q[c*CH_BITS +: CH_BITS];
      end
    end else if (i_we && cpu_ok) begin
      mem[back][cpu_ch_i][cpu_idx] <= i_wdata[CH_BITS-1:0];
    end
  end

  // CPU read response and error pulse, one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= i_re && !i_we;
      o_err    <= (i_we && !cpu_ok) || (i_re && (i_we || !cpu_ok));
      if (i_re && !i_we) begin
        o_rdata <= cpu_ok ? 32'(mem[back][cpu_ch_i][cpu_idx]) : 32'd0;
      end
    end
  end

  // Display fetch from the front bank; colour holds when no request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_color       <= '0;
      o_color_valid <= 1'b0;
    end else begin
      o_color_valid <= i_pxl_req;
      if (i_pxl_req) begin
        o_color <= pxl_ok ? pxl_word : '0;
      end
    end
  end

  // Clear FSM: sweep every index of the back bank once, ascending.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_busy    <= 1'b0;
      clr_idx   <= '0;
      clr_val_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_clr_req) begin
            state     <= ST_CLEAR;
            o_busy    <= 1'b1;
            clr_idx   <= '0;
            clr_val_q <= i_clr_val;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == IDX_W'(NPIX - 1)) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Swap request is remembered and applied at a frame boundary outside a clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_front <= 1'b0;
      pending <= 1'b0;
    end else if (i_frame_start && (pending || i_swap_req) && !o_busy) begin
      o_front <= ~o_front;
      pending <= 1'b0;
    end else if (i_swap_req) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_framebuf_db.sv
// tb/tb_vga_framebuf_db.sv - self-checking bench for vga_framebuf_db
module tb_vga_framebuf_db;

  localparam int H = 160;
  localparam int V = 120;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        clr_req = 1'b0;
  logic [11:0] clr_val = '0;
  logic        busy;
  logic        swap_req = 1'b0;
  logic        frame_start = 1'b0;
  logic        front;
  logic        pxl_req = 1'b0;
  logic [7:0]  pxl_x = '0;
  logic [7:0]  pxl_y = '0;
  logic [11:0] color;
  logic        color_valid;

  vga_framebuf_db dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata),
    .i_we(we), .i_re(re), .o_rdata(rdata), .o_rvalid(rvalid), .o_err(err),
    .i_clr_req(clr_req), .i_clr_val(clr_val), .o_busy(busy),
    .i_swap_req(swap_req), .i_frame_start(frame_start), .o_front(front),
    .i_pxl_req(pxl_req), .i_pxlX(pxl_x), .i_pxlY(pxl_y),
    .o_color(color), .o_color_valid(color_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  bit check_en = 0;

  // Reference framebuffer contents; mk marks words whose value is defined.
  logic [3:0] m  [2][3][NPIX];
  bit         mk [2][3][NPIX];
  int         m_front = 0;
  bit         m_pend = 0;
  bit         m_clr_on = 0;
  int         m_clr_pos = 0;
  logic [11:0] m_clr_val = '0;

  logic [31:0] nx_rdata = '0, exp_rdata = '0;
  bit nx_rk = 0, exp_rk = 0;
  bit nx_rvalid = 0, exp_rvalid = 0;
  bit nx_err = 0, exp_err = 0;
  logic [11:0] nx_color = '0, exp_color = '0;
  bit nx_ck = 0, exp_ck = 0;
  bit nx_cvalid = 0, exp_cvalid = 0;
  bit nx_busy = 0, exp_busy = 0;
  bit nx_front = 0, exp_front = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Compute what the outputs must be after the coming edge, then commit model state.
  task automatic model_step();
    int x, y, ch, idx, b, pidx;
    bit ok, busy0;
    if (!rst_n) begin
      nx_rdata = '0; nx_rk = 1; nx_rvalid = 0; nx_err = 0;
      nx_color = '0; nx_ck = 1; nx_cvalid = 0;
      if (m_clr_on) for (int c = 0; c < 3; c++) mk[1 - m_front][c][m_clr_pos] = 0;
      m_clr_on = 0; m_front = 0; m_pend = 0;
      nx_busy = 0; nx_front = 0;
      return;
    end
    busy0 = m_clr_on;
    b  = 1 - m_front;
    x  = int'(addr[7:0]);
    y  = int'(addr[15:8]);
    ch = int'(addr[23:16]);
    ok = (x < H) && (y < V) && (ch < 3) && !busy0;
    idx = y * H + x;
    nx_rvalid = re && !we;
    nx_err = (we && !ok) || (re && (we || !ok));
    if (re && !we) begin
      if (ok) begin nx_rdata = 32'(m[b][ch][idx]); nx_rk = mk[b][ch][idx]; end
      else begin nx_rdata = '0; nx_rk = 1; end
    end
    nx_cvalid = pxl_req;
    if (pxl_req) begin
      nx_color = '0; nx_ck = 1;
      if (int'(pxl_x) < H && int'(pxl_y) < V) begin
        pidx = int'(pxl_y) * H + int'(pxl_x);
        for (int c = 0; c < 3; c++) begin
          nx_color = nx_color | (12'(m[m_front][c][pidx]) << (4 * c));
          nx_ck = nx_ck && mk[m_front][c][pidx];
        end
      end
    end
    if (we && ok) begin m[b][ch][idx] = wdata[3:0]; mk[b][ch][idx] = 1; end
    if (m_clr_on) begin
      for (int c = 0; c < 3; c++) begin
        m[b][c][m_clr_pos] = m_clr_val[4*c +: 4];
        mk[b][c][m_clr_pos] = 1;
      end
      m_clr_pos++;
      if (m_clr_pos == NPIX) m_clr_on = 0;
    end else if (clr_req) begin
      m_clr_on = 1; m_clr_pos = 0; m_clr_val = clr_val;
    end
    if (frame_start && (m_pend || swap_req) && !busy0) begin
      m_front = 1 - m_front; m_pend = 0;
    end else if (swap_req) begin
      m_pend = 1;
    end
    nx_busy = m_clr_on;
    nx_front = (m_front != 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    exp_rdata = nx_rdata; exp_rk = nx_rk; exp_rvalid = nx_rvalid; exp_err = nx_err;
    exp_color = nx_color; exp_ck = nx_ck; exp_cvalid = nx_cvalid;
    exp_busy = nx_busy; exp_front = nx_front;
    #1;
  endtask

  // Every-cycle comparison of the DUT against the reference.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("rvalid", 32'(rvalid), 32'(exp_rvalid));
      cmp("err", 32'(err), 32'(exp_err));
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("front", 32'(front), 32'(exp_front));
      cmp("color_valid", 32'(color_valid), 32'(exp_cvalid));
      if (exp_rk) cmp("rdata", rdata, exp_rdata);
      if (exp_ck) cmp("color", 32'(color), 32'(exp_color));
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1; tick(); we = 0;
  endtask

  task automatic cpu_rd(input logic [31:0] a);
    addr = a; re = 1; tick(); re = 0;
  endtask

  initial begin
    rst_n = 0;
    tick();
    check_en = 1;
    tick(); tick();
    cmp("reset_front", 32'(front), 32'd0);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_rvalid", 32'(rvalid), 32'd0);
    cmp("reset_color", {20'd0, color}, 32'd0);
    rst_n = 1;
    tick();

    // Pixel (3,2) of back bank 1, then swap it to the front and fetch.
    cpu_wr(32'h0000_0203, 32'h0);
    cpu_wr(32'h0001_0203, 32'hA);
    cpu_wr(32'h0002_0203, 32'h0);
    swap_req = 1; frame_start = 1; tick(); swap_req = 0; frame_start = 0;
    cmp("swap_front", 32'(front), 32'd1);
    pxl_req = 1; pxl_x = 8'd3; pxl_y = 8'd2; tick(); pxl_req = 0;
    cmp("pix32_color", {20'd0, color}, 32'h0A0);
    cmp("pix32_valid", 32'(color_valid), 32'd1);

    // Write then read back on bank 0.
    cpu_wr(32'h0002_0505, 32'h7);
    cpu_rd(32'h0002_0505);
    cmp("rd_rvalid", 32'(rvalid), 32'd1);
    cmp("rd_data", rdata, 32'h7);
    cmp("rd_err", 32'(err), 32'd0);

    // Rejected accesses and out-of-range fetch.
    cpu_wr(32'h0000_00A0, 32'h3);
    cmp("wr_x160_err", 32'(err), 32'd1);
    cpu_wr(32'h0003_0505, 32'h1);
    cmp("wr_ch3_err", 32'(err), 32'd1);
    cpu_rd(32'h0002_0505);
    cmp("rd_unchanged", rdata, 32'h7);
    pxl_req = 1; pxl_x = 8'd200; pxl_y = 8'd0; tick(); pxl_req = 0;
    cmp("pix200_color", {20'd0, color}, 32'h0);
    cmp("pix200_valid", 32'(color_valid), 32'd1);
    cpu_rd(32'h0000_7800);
    cmp("rd_bad_rvalid", 32'(rvalid), 32'd1);
    cmp("rd_bad_data", rdata, 32'h0);
    cmp("rd_bad_err", 32'(err), 32'd1);
    addr = 32'h0; wdata = 32'h5; we = 1; re = 1; tick(); we = 0; re = 0;
    cmp("wr_rd_rvalid", 32'(rvalid), 32'd0);
    cmp("wr_rd_err", 32'(err), 32'd1);
    cpu_rd(32'h0);
    cmp("wr_rd_data", rdata, 32'h5);

    // Pending swap waits for a frame boundary and fires once.
    swap_req = 1; tick(); swap_req = 0;
    for (int i = 0; i < 10; i++) tick();
    cmp("pend_hold", 32'(front), 32'd1);
    frame_start = 1; tick(); frame_start = 0;
    cmp("pend_swap", 32'(front), 32'd0);
    tick();
    frame_start = 1; tick(); frame_start = 0;
    cmp("no_second_swap", 32'(front), 32'd0);

    // Full clear of bank 1 with a busy write, ignored re-request and deferred swap.
    busy_cnt = 0;
    clr_val = 12'h123; clr_req = 1; tick(); clr_req = 0;
    for (int i = 0; i < NPIX + 10; i++) begin
      if (i == 500) begin cpu_wr(32'h0, 32'h9); cmp("busy_wr_err", 32'(err), 32'd1); end
      else if (i == 800) begin clr_val = 12'hFFF; clr_req = 1; tick(); clr_req = 0; end
      else if (i == 1000) begin swap_req = 1; tick(); swap_req = 0; end
      else if (i == 2000) begin frame_start = 1; tick(); frame_start = 0; end
      else tick();
    end
    cmp("busy_cycles", busy_cnt, 32'd19200);
    cmp("busy_deferred_swap", 32'(front), 32'd0);
    cpu_rd(32'h0001_0907);
    cmp("clr_ch1", rdata, 32'h2);
    frame_start = 1; tick(); frame_start = 0;
    cmp("post_clr_swap", 32'(front), 32'd1);

    // Reset part-way through a clear of bank 1.
    swap_req = 1; frame_start = 1; tick(); swap_req = 0; frame_start = 0;
    clr_val = 12'h456; clr_req = 1; tick(); clr_req = 0;
    for (int i = 0; i < 99; i++) tick();
    rst_n = 0; tick(); rst_n = 1;
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_front", 32'(front), 32'd0);
    cpu_rd(32'h0000_0032);
    cmp("rst_idx50", rdata, 32'h6);
    cpu_rd(32'h0002_1F28);
    cmp("rst_idx5000", rdata, 32'h1);
    tick();

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
